// File: rtl/enc_pkg.sv
// Shared constants and width helper for the pending priority encoder.
package enc_pkg;

  localparam int unsigned MODE_FIXED = 0;
  localparam int unsigned MODE_RR    = 1;

  // Index width for a vector of 'value' entries; never narrower than one bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/pending_priority_encoder_prio_pick.sv
// Combinational pick of one set bit: highest index (fixed) or first at/after base (round-robin).
module prio_pick
  import enc_pkg::*;
#(
  parameter  int unsigned N = 8,
  localparam int unsigned W = clog2(N)
) (
  input  logic [N-1:0] vec_i,
  input  logic [W-1:0] base_i,
  input  logic         mode_i,
  output logic [W-1:0] idx_c_o,
  output logic         found_c_o
);

  // One extra bit so base + offset never overflows before the modulo-N fold.
  localparam int unsigned WP = W + 1;

  logic [WP-1:0] pos;

  // Scan order makes the preferred candidate the last one written.
  always_comb begin
    idx_c_o   = '0;
    found_c_o = 1'b0;
    pos       = '0;
    if (!mode_i) begin
      for (int i = 0; i < int'(N); i++) begin
        if (vec_i[i]) begin
          idx_c_o   = W'(i);
          found_c_o = 1'b1;
        end
      end
    end else begin
      for (int k = int'(N) - 1; k >= 0; k--) begin
        pos = {1'b0, base_i} + WP'(k);
        if (pos >= WP'(N)) begin
          pos = pos - WP'(N);
        end
        if (vec_i[W'(pos)]) begin
          idx_c_o   = W'(pos);
          found_c_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pending_priority_encoder.sv
// Sticky request capture feeding a one-entry valid/ready grant register.
module pending_priority_encoder
  import enc_pkg::*;
#(
  parameter  int unsigned N    = 8,
  parameter  int unsigned MODE = MODE_FIXED,
  localparam int unsigned W    = clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [W-1:0] q,
  output logic         valid,
  input  logic         ready,
  output logic [N-1:0] pending,
  output logic         multi
);

  localparam logic [0:0]   ST_EMPTY = 1'b0;
  localparam logic [0:0]   ST_FULL  = 1'b1;
  localparam logic         MODE_BIT = (MODE == MODE_RR);
  localparam logic [W-1:0] LAST_IDX = W'(N - 1);

  logic [0:0]   state_q, state_d;
  logic [N-1:0] pend_q, pend_d;
  logic [W-1:0] grant_q, grant_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic         multi_q, multi_d;

  logic [W-1:0] pick_idx;
  logic         pick_found;
  logic         load;
  logic [N-1:0] clr;

  // Candidate selection always works from the registered pending vector.
  prio_pick #(
    .N (N)
  ) u_pick (
    .vec_i     (pend_q),
    .base_i    (ptr_q),
    .mode_i    (MODE_BIT),
    .idx_c_o   (pick_idx),
    .found_c_o (pick_found)
  );

  // Next state: grant load/consume, pending clear-then-set, pointer advance, multi detect.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    clr     = '0;
    load    = 1'b0;

    case (state_q)
      ST_EMPTY: begin
        if (pick_found) begin
          load    = 1'b1;
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (ready) begin
          if (pick_found) begin
            load = 1'b1;
          end else begin
            state_d = ST_EMPTY;
          end
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    if (load) begin
      grant_d       = pick_idx;
      clr[pick_idx] = 1'b1;
      ptr_d         = (pick_idx == LAST_IDX) ? '0 : pick_idx + W'(1);
    end

    // A bit requested in the cycle it is granted stays pending.
    pend_d  = (pend_q & ~clr) | (en ? d : '0);
    multi_d = en && ((d & (d - N'(1))) != '0);
  end

  // State registers; reset drops all pending work and any held grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      pend_q  <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
      multi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      multi_q <= multi_d;
    end
  end

  assign q       = grant_q;
  assign valid   = (state_q == ST_FULL);
  assign pending = pend_q;
  assign multi   = multi_q;

endmodule

// File: tb/tb_pending_priority_encoder.sv
// Bench: fixed N=8, round-robin N=8 and round-robin N=5 encoders driven in lockstep.
module tb_pending_priority_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, ready;
  logic [7:0] d;

  logic [2:0] q_f, q_r, q_5;
  logic       v_f, v_r, v_5;
  logic       m_f, m_r, m_5;
  logic [7:0] p_f, p_r;
  logic [4:0] p_5;

  pending_priority_encoder #(.N(8), .MODE(0)) dut_f (
    .clk(clk), .rst(rst), .en(en), .d(d), .q(q_f), .valid(v_f),
    .ready(ready), .pending(p_f), .multi(m_f));

  pending_priority_encoder #(.N(8), .MODE(1)) dut_r (
    .clk(clk), .rst(rst), .en(en), .d(d), .q(q_r), .valid(v_r),
    .ready(ready), .pending(p_r), .multi(m_r));

  pending_priority_encoder #(.N(5), .MODE(1)) dut_5 (
    .clk(clk), .rst(rst), .en(en), .d(d[4:0]), .q(q_5), .valid(v_5),
    .ready(ready), .pending(p_5), .multi(m_5));

  int nchk = 0;
  int nerr = 0;

  // Reference model: one entry per DUT, written from the behavioural rules.
  int        m_n[3]    = '{8, 8, 5};
  int        m_mode[3] = '{0, 1, 1};
  bit [63:0] m_pend[3];
  int        m_q[3];
  int        m_ptr[3];
  bit        m_valid[3];
  bit        m_multi[3];

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      m_pend[k] = '0; m_q[k] = 0; m_ptr[k] = 0; m_valid[k] = 0; m_multi[k] = 0;
    end
  endfunction

  function automatic void model_step(int k, bit e, logic [7:0] dv, bit r);
    bit [63:0] dd;
    int idx, n, j;
    n   = m_n[k];
    dd  = 64'(dv) & ((64'd1 << n) - 64'd1);
    idx = -1;
    if (!m_valid[k] || r) begin
      if (m_mode[k] == 0) begin
        for (int i = n - 1; i >= 0; i--)
          if (idx < 0 && m_pend[k][i]) idx = i;
      end else begin
        for (int s = 0; s < n; s++) begin
          j = (m_ptr[k] + s) % n;
          if (idx < 0 && m_pend[k][j]) idx = j;
        end
      end
      if (idx >= 0) begin
        m_q[k] = idx; m_valid[k] = 1; m_pend[k][idx] = 1'b0;
        m_ptr[k] = (idx + 1) % n;
      end else begin
        m_valid[k] = 0;
      end
    end
    if (e) m_pend[k] = m_pend[k] | dd;
    m_multi[k] = e && ($countones(dd) > 1);
  endfunction

  function automatic logic [73:0] observed(int k);
    case (k)
      0:       return {8'(q_f), v_f, m_f, 64'(p_f)};
      1:       return {8'(q_r), v_r, m_r, 64'(p_r)};
      default: return {8'(q_5), v_5, m_5, 64'(p_5)};
    endcase
  endfunction

  function automatic logic [73:0] expected(int k);
    return {8'(m_q[k]), m_valid[k], m_multi[k], m_pend[k]};
  endfunction

  // One clock of stimulus: advance the model, cross the edge, settle past it.
  task automatic cyc(input bit e, input logic [7:0] dv, input bit r);
    en = e; d = dv; ready = r;
    for (int k = 0; k < 3; k++) model_step(k, e, dv, r);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; d = '0; ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    nchk++;
    if ({q_f, v_f, m_f, p_f} !== 13'h0) begin
      nerr++; $display("FAIL reset_state got=%h want=0", {q_f, v_f, m_f, p_f});
    end
    rst = 1'b0;
    cyc(1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 3; k++) begin
      nchk++;
      if (observed(k) !== expected(k)) begin
        nerr++; $display("FAIL reset_model dut%0d got=%h want=%h", k, observed(k), expected(k));
      end
    end
  endtask

  task automatic test_rr();
    int prev_r, prev_5;
    prev_r = 0; prev_5 = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 8'hFF, 1'b1);
      for (int k = 0; k < 3; k++) begin
        nchk++;
        if (observed(k) !== expected(k)) begin
          nerr++; $display("FAIL rr_model dut%0d cyc%0d got=%h want=%h", k, i, observed(k), expected(k));
        end
      end
      if (i >= 1) begin
        nchk++;
        if (v_r !== 1'b1 || v_5 !== 1'b1) begin
          nerr++; $display("FAIL rr_valid cyc%0d got=%b%b want=11", i, v_r, v_5);
        end
      end
      if (i == 1) begin
        nchk++;
        if (q_r !== 3'd0 || q_5 !== 3'd0) begin
          nerr++; $display("FAIL rr_first cyc%0d got=%0d,%0d want=0,0", i, q_r, q_5);
        end
      end
      if (i >= 2) begin
        nchk++;
        if (q_r !== 3'((prev_r + 1) % 8) || q_5 !== 3'((prev_5 + 1) % 5)) begin
          nerr++;
          $display("FAIL rr_seq cyc%0d got=%0d,%0d want=%0d,%0d", i, q_r, q_5,
                   (prev_r + 1) % 8, (prev_5 + 1) % 5);
        end
      end
      prev_r = int'(q_r); prev_5 = int'(q_5);
    end
    idle(12);
  endtask

  task automatic test_single();
    cyc(1'b1, 8'h10, 1'b1);
    nchk++;
    if (p_f !== 8'h10 || v_f !== 1'b0) begin
      nerr++; $display("FAIL single_c1 got p=%h v=%b want p=10 v=0", p_f, v_f);
    end
    cyc(1'b0, 8'h00, 1'b1);
    nchk++;
    if (v_f !== 1'b1 || q_f !== 3'd4 || p_f !== 8'h00) begin
      nerr++; $display("FAIL single_c2 got v=%b q=%0d p=%h want v=1 q=4 p=00", v_f, q_f, p_f);
    end
    for (int k = 1; k < 3; k++) begin
      nchk++;
      if (observed(k) !== expected(k)) begin
        nerr++; $display("FAIL single_model dut%0d got=%h want=%h", k, observed(k), expected(k));
      end
    end
    cyc(1'b0, 8'h00, 1'b1);
    nchk++;
    if (v_f !== 1'b0) begin
      nerr++; $display("FAIL single_c3 got v=%b want v=0", v_f);
    end
    idle(4);
  endtask

  task automatic test_fixed_burst();
    int want[3] = '{7, 2, 0};
    int pulses;
    pulses = 0;
    cyc(1'b1, 8'h85, 1'b1);
    if (m_f) pulses++;
    nchk++;
    if (p_f !== 8'h85) begin
      nerr++; $display("FAIL burst_pend got=%h want=85", p_f);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      if (m_f) pulses++;
      nchk++;
      if (v_f !== 1'b1 || q_f !== 3'(want[i])) begin
        nerr++; $display("FAIL burst_q step%0d got v=%b q=%0d want v=1 q=%0d", i, v_f, q_f, want[i]);
      end
    end
    cyc(1'b0, 8'h00, 1'b1);
    nchk++;
    if (v_f !== 1'b0 || pulses != 1) begin
      nerr++; $display("FAIL burst_end got v=%b pulses=%0d want v=0 pulses=1", v_f, pulses);
    end
    idle(6);
  endtask

  task automatic test_backpressure();
    cyc(1'b1, 8'h81, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 8'h00, 1'b0);
      nchk++;
      if (v_f !== 1'b1 || q_f !== 3'd7 || p_f !== 8'h01) begin
        nerr++; $display("FAIL bp_hold cyc%0d got v=%b q=%0d p=%h want v=1 q=7 p=01", i, v_f, q_f, p_f);
      end
    end
    cyc(1'b0, 8'h00, 1'b1);
    nchk++;
    if (v_f !== 1'b1 || q_f !== 3'd0 || p_f !== 8'h00) begin
      nerr++; $display("FAIL bp_next got v=%b q=%0d p=%h want v=1 q=0 p=00", v_f, q_f, p_f);
    end
    cyc(1'b0, 8'h00, 1'b1);
    nchk++;
    if (v_f !== 1'b0) begin
      nerr++; $display("FAIL bp_drain got v=%b want 0", v_f);
    end
    for (int k = 0; k < 3; k++) begin
      nchk++;
      if (observed(k) !== expected(k)) begin
        nerr++; $display("FAIL bp_model dut%0d got=%h want=%h", k, observed(k), expected(k));
      end
    end
    idle(6);
  endtask

  task automatic test_set_wins();
    cyc(1'b1, 8'h08, 1'b1);
    cyc(1'b1, 8'h08, 1'b1);
    nchk++;
    if (v_f !== 1'b1 || q_f !== 3'd3 || p_f[3] !== 1'b1) begin
      nerr++; $display("FAIL setwins_first got v=%b q=%0d p=%h want v=1 q=3 p[3]=1", v_f, q_f, p_f);
    end
    cyc(1'b0, 8'h00, 1'b1);
    nchk++;
    if (v_f !== 1'b1 || q_f !== 3'd3 || p_f !== 8'h00) begin
      nerr++; $display("FAIL setwins_again got v=%b q=%0d p=%h want v=1 q=3 p=00", v_f, q_f, p_f);
    end
    idle(6);
  endtask

  task automatic test_random();
    logic [7:0] dv;
    for (int i = 0; i < 400; i++) begin
      dv = 8'($urandom) & 8'($urandom);
      cyc(1'($urandom_range(0, 1)), dv, $urandom_range(0, 3) != 0);
      for (int k = 0; k < 3; k++) begin
        nchk++;
        if (observed(k) !== expected(k)) begin
          nerr++; $display("FAIL random dut%0d cyc%0d got=%h want=%h", k, i, observed(k), expected(k));
        end
      end
    end
    idle(10);
  endtask

  task automatic test_async_reset();
    cyc(1'b1, 8'h0F, 1'b0);
    cyc(1'b1, 8'h0F, 1'b0);
    nchk++;
    if (v_f !== 1'b1 || q_f !== 3'd3 || p_f !== 8'h0F) begin
      nerr++; $display("FAIL arst_setup got v=%b q=%0d p=%h want v=1 q=3 p=0F", v_f, q_f, p_f);
    end
    en = 1'b0; d = '0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    nchk++;
    if (q_f !== 3'd0 || v_f !== 1'b0 || p_f !== 8'h00 || v_r !== 1'b0 || p_5 !== 5'h00) begin
      nerr++; $display("FAIL arst_immediate got q=%0d v=%b p=%h want q=0 v=0 p=00", q_f, v_f, p_f);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 8'hFF, 1'b1);
      for (int k = 0; k < 3; k++) begin
        nchk++;
        if (observed(k) !== expected(k)) begin
          nerr++; $display("FAIL arst_idle dut%0d cyc%0d got=%h want=%h", k, i, observed(k), expected(k));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_rr();
    test_single();
    test_fixed_burst();
    test_backpressure();
    test_set_wins();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
